bw_idct_tagctl: RTL and testbench
=================================

BW_IDCT_TAGCTL -- requirements
Module: bw_idct_tagctl

Interface
REQ-001 Parameters SHALL be: IDX_W, 7, set index width; TAG_W, 33, tag entry width (bit TAG_W-1 = valid, bits TAG_W-2:0 = ptag).
REQ-002 Ports SHALL be (name direction width meaning), one per line:
 rclk  in  1  sole clock, rising edge
 reset_l  in  1  asynchronous active-low reset
 lkp_vld  in  1  lookup request
 lkp_rdy  out  1  lookup may be accepted this cycle
 lkp_index  in  IDX_W  lookup set index
 lkp_ptag  in  TAG_W-1  lookup physical tag
 rdtag_w0_y..rdtag_w3_y  in  TAG_W each  way tags from tag array, one cycle after rdreq_x
 index_x  out  IDX_W  tag array index
 rdreq_x  out  1  tag array read
 wrreq_x  out  1  tag array write
 dec_wrway_x  out  4  one-hot write way
 wrtag_y  out  TAG_W  write data, fanned to all four wrtag ports
 res_vld  out  1  lookup result valid
 res_hit  out  1  hit
 res_way  out  4  matching ways
 res_mhit  out  1  multi-way hit error
 fill_req  out  1  miss fill request
 fill_index  out  IDX_W  fill set index
 fill_ptag  out  TAG_W-1  fill tag
 fill_ack  in  1  fill complete

Function
REQ-003 Lookup SHALL be accepted when lkp_vld & lkp_rdy (cycle X); rdreq_x SHALL equal lkp_vld & lkp_rdy, index_x = lkp_index.
REQ-004 Accepted index/ptag SHALL be registered into the Y stage with y_vld; compare at Y: way n matches iff rdtag_wn_y[TAG_W-1]=1 and rdtag_wn_y[TAG_W-2:0]=ptag_y.
REQ-005 Results SHALL be registered: res_vld/res_hit/res_way/res_mhit visible at X+2; res_vld a one-cycle pulse per accepted lookup.
REQ-006 res_mhit SHALL be 1 when more than one way matches; res_hit=1 and res_way shows all matching bits.
REQ-007 lkp_rdy SHALL = (state==IDLE) & ~(y_vld & no match); back-to-back lookups SHALL sustain one per cycle while hitting.
REQ-008 FSM states: IDLE, FILL, TAGWR. IDLE->FILL when Y misses; FILL->TAGWR on fill_ack; TAGWR->IDLE after exactly one cycle.
REQ-009 On Y miss, fill_index/fill_ptag/victim way SHALL be captured; fill_req SHALL be 1 throughout FILL, 0 otherwise.
REQ-010 fill_ack SHALL be honoured in the first FILL cycle; ignored outside FILL.
REQ-011 In TAGWR: wrreq_x=1, rdreq_x=0, index_x=fill_index, dec_wrway_x=victim one-hot, wrtag_y={1'b1,fill_ptag}; otherwise wrreq_x=0, dec_wrway_x=0.
REQ-012 Victim SHALL be the lowest-numbered way with valid=0; if all valid, the 2-bit round-robin pointer value.
REQ-013 Round-robin pointer SHALL increment (wrap 3->0) on each TAGWR cycle that used it; unchanged when an invalid way was chosen.

Reset
REQ-014 reset_l low SHALL immediately force: state IDLE, y_vld=0, res_vld=0, res_hit=0, res_way=0, res_mhit=0, fill_req=0, wrreq_x=0, dec_wrway_x=0, RR pointer=0.
REQ-015 Reset during FILL or TAGWR SHALL abandon the fill with no tag write; lkp_rdy=1 on first cycle after release.

Verification
REQ-016 Hit: lookup idx=5 ptag=0x1234, rdtag_w2_y={1,0x1234} -> res_vld, res_hit=1, res_way=0100, res_mhit=0 at X+2, no fill_req.
REQ-017 Miss with invalid way: all ways mismatch, w1 valid=0 -> lkp_rdy=0, fill_req until fill_ack, then one cycle wrreq_x=1, dec_wrway_x=0010, index_x=5, wrtag_y={1,0x1234}.
REQ-018 Round-robin: four all-valid misses -> dec_wrway_x 0001,0010,0100,1000, fifth 0001.
REQ-019 Multi-hit: w0 and w3 match -> res_hit=1, res_way=1001, res_mhit=1.
REQ-020 Back-to-back: hits in 4 consecutive cycles -> 4 consecutive res_vld pulses; miss at Y blocks next X (rdreq_x=0) that cycle.
REQ-021 Reset asserted mid-FILL -> fill_req=0 immediately, no wrreq_x after release, RR pointer=0.

Source files
------------

// File: rtl/bw_idct_tagctl.sv
// Tag-array lookup controller: two-stage (X/Y) lookup against a 4-way tag array,
// a registered hit/miss result, and a miss fill sequence that writes the victim way.
module bw_idct_tagctl #(
  parameter int unsigned IDX_W = 7,
  parameter int unsigned TAG_W = 33
) (
  input  logic             rclk,
  input  logic             reset_l,
  input  logic             lkp_vld,
  output logic             lkp_rdy,
  input  logic [IDX_W-1:0] lkp_index,
  input  logic [TAG_W-2:0] lkp_ptag,
  input  logic [TAG_W-1:0] rdtag_w0_y,
  input  logic [TAG_W-1:0] rdtag_w1_y,
  input  logic [TAG_W-1:0] rdtag_w2_y,
  input  logic [TAG_W-1:0] rdtag_w3_y,
  output logic [IDX_W-1:0] index_x,
  output logic             rdreq_x,
  output logic             wrreq_x,
  output logic [3:0]       dec_wrway_x,
  output logic [TAG_W-1:0] wrtag_y,
  output logic             res_vld,
  output logic             res_hit,
  output logic [3:0]       res_way,
  output logic             res_mhit,
  output logic             fill_req,
  output logic [IDX_W-1:0] fill_index,
  output logic [TAG_W-2:0] fill_ptag,
  input  logic             fill_ack
);

  typedef enum logic [1:0] {StIdle, StFill, StTagwr} state_e;

  state_e           r_state, w_state_nxt;
  logic             r_y_vld;
  logic [IDX_W-1:0] r_y_index;
  logic [TAG_W-2:0] r_y_ptag;
  logic [3:0]       r_victim;
  logic             r_victim_rr;
  logic [1:0]       r_rr;

  logic [3:0]       w_valid;
  logic [3:0]       w_match;
  logic             w_y_miss;
  logic             w_accept;
  logic [3:0]       w_victim;
  logic             w_victim_rr;

  assign w_valid = {rdtag_w3_y[TAG_W-1], rdtag_w2_y[TAG_W-1],
                    rdtag_w1_y[TAG_W-1], rdtag_w0_y[TAG_W-1]};

  // Per-way compare: valid bit set and stored ptag equal to the Y-stage ptag
  always_comb begin
    w_match[0] = w_valid[0] & (rdtag_w0_y[TAG_W-2:0] == r_y_ptag);
    w_match[1] = w_valid[1] & (rdtag_w1_y[TAG_W-2:0] == r_y_ptag);
    w_match[2] = w_valid[2] & (rdtag_w2_y[TAG_W-2:0] == r_y_ptag);
    w_match[3] = w_valid[3] & (rdtag_w3_y[TAG_W-2:0] == r_y_ptag);
  end

  assign w_y_miss = r_y_vld & ~(|w_match);
  // A Y miss stalls the X stage in the same cycle so no lookup slips past the fill
  assign lkp_rdy  = (r_state == StIdle) & ~w_y_miss;
  assign w_accept = lkp_vld & lkp_rdy;

  // Victim select: lowest invalid way, else the round-robin pointer
  always_comb begin
    w_victim    = 4'b0001 << r_rr;
    w_victim_rr = 1'b1;
    if (!w_valid[0]) begin
      w_victim    = 4'b0001;
      w_victim_rr = 1'b0;
    end else if (!w_valid[1]) begin
      w_victim    = 4'b0010;
      w_victim_rr = 1'b0;
    end else if (!w_valid[2]) begin
      w_victim    = 4'b0100;
      w_victim_rr = 1'b0;
    end else if (!w_valid[3]) begin
      w_victim    = 4'b1000;
      w_victim_rr = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge rclk or negedge reset_l) begin
    if (!reset_l) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  // FSM next state and tag-array command outputs
  always_comb begin
    w_state_nxt = r_state;
    rdreq_x     = w_accept;
    index_x     = lkp_index;
    wrreq_x     = 1'b0;
    dec_wrway_x = 4'b0000;
    wrtag_y     = '0;
    fill_req    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_y_miss) w_state_nxt = StFill;
      end
      StFill: begin
        fill_req = 1'b1;
        if (fill_ack) w_state_nxt = StTagwr;
      end
      StTagwr: begin
        rdreq_x     = 1'b0;
        wrreq_x     = 1'b1;
        index_x     = fill_index;
        dec_wrway_x = r_victim;
        wrtag_y     = {1'b1, fill_ptag};
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Y-stage capture of the accepted lookup
  always_ff @(posedge rclk or negedge reset_l) begin
    if (!reset_l) begin
      r_y_vld   <= 1'b0;
      r_y_index <= '0;
      r_y_ptag  <= '0;
    end else begin
      r_y_vld <= w_accept;
      if (w_accept) begin
        r_y_index <= lkp_index;
        r_y_ptag  <= lkp_ptag;
      end
    end
  end

  // Registered lookup result, one pulse per Y-stage lookup
  always_ff @(posedge rclk or negedge reset_l) begin
    if (!reset_l) begin
      res_vld  <= 1'b0;
      res_hit  <= 1'b0;
      res_way  <= 4'b0000;
      res_mhit <= 1'b0;
    end else begin
      res_vld  <= r_y_vld;
      res_hit  <= r_y_vld & (|w_match);
      res_way  <= r_y_vld ? w_match : 4'b0000;
      res_mhit <= r_y_vld & (|(w_match & (w_match - 4'd1)));
    end
  end

  // Fill context captured on a Y miss; RR pointer advances only when it picked the victim
  always_ff @(posedge rclk or negedge reset_l) begin
    if (!reset_l) begin
      fill_index  <= '0;
      fill_ptag   <= '0;
      r_victim    <= 4'b0000;
      r_victim_rr <= 1'b0;
      r_rr        <= 2'd0;
    end else begin
      if (r_state == StIdle && w_y_miss) begin
        fill_index  <= r_y_index;
        fill_ptag   <= r_y_ptag;
        r_victim    <= w_victim;
        r_victim_rr <= w_victim_rr;
      end
      if (r_state == StTagwr && r_victim_rr) r_rr <= r_rr + 2'd1;
    end
  end

endmodule

// File: tb/tb_bw_idct_tagctl.sv
module tb_bw_idct_tagctl;
  localparam int unsigned IDX_W = 7;
  localparam int unsigned TAG_W = 33;

  logic             rclk = 1'b0;
  logic             reset_l;
  logic             lkp_vld;
  logic             lkp_rdy;
  logic [IDX_W-1:0] lkp_index;
  logic [TAG_W-2:0] lkp_ptag;
  logic [3:0][TAG_W-1:0] tags;
  logic [IDX_W-1:0] index_x;
  logic             rdreq_x;
  logic             wrreq_x;
  logic [3:0]       dec_wrway_x;
  logic [TAG_W-1:0] wrtag_y;
  logic             res_vld;
  logic             res_hit;
  logic [3:0]       res_way;
  logic             res_mhit;
  logic             fill_req;
  logic [IDX_W-1:0] fill_index;
  logic [TAG_W-2:0] fill_ptag;
  logic             fill_ack;

  int n_checks = 0;
  int n_errors = 0;

  always #5 rclk = ~rclk;

  bw_idct_tagctl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .rclk        (rclk),
    .reset_l     (reset_l),
    .lkp_vld     (lkp_vld),
    .lkp_rdy     (lkp_rdy),
    .lkp_index   (lkp_index),
    .lkp_ptag    (lkp_ptag),
    .rdtag_w0_y  (tags[0]),
    .rdtag_w1_y  (tags[1]),
    .rdtag_w2_y  (tags[2]),
    .rdtag_w3_y  (tags[3]),
    .index_x     (index_x),
    .rdreq_x     (rdreq_x),
    .wrreq_x     (wrreq_x),
    .dec_wrway_x (dec_wrway_x),
    .wrtag_y     (wrtag_y),
    .res_vld     (res_vld),
    .res_hit     (res_hit),
    .res_way     (res_way),
    .res_mhit    (res_mhit),
    .fill_req    (fill_req),
    .fill_index  (fill_index),
    .fill_ptag   (fill_ptag),
    .fill_ack    (fill_ack)
  );

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-2:0] ptag;
    logic [TAG_W-1:0] t0, t1, t2, t3;
    logic             hit;
    logic [3:0]       way;
    logic             mhit;
    logic [3:0]       victim;
    int               ack_wait;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [IDX_W-1:0] idx, input logic [TAG_W-2:0] ptag,
                              input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                              input logic [TAG_W-1:0] t2, input logic [TAG_W-1:0] t3,
                              input logic hit, input logic [3:0] way, input logic mhit,
                              input logic [3:0] victim, input int ack_wait);
    vec_t v;
    v.idx = idx; v.ptag = ptag; v.t0 = t0; v.t1 = t1; v.t2 = t2; v.t3 = t3;
    v.hit = hit; v.way = way; v.mhit = mhit; v.victim = victim; v.ack_wait = ack_wait;
    return v;
  endfunction

  // One complete lookup, and for a miss the whole fill/tag-write sequence
  task automatic run_vec(input vec_t v);
    @(negedge rclk);
    lkp_vld = 1'b1; lkp_index = v.idx; lkp_ptag = v.ptag;
    #1;
    chk("x_rdy", lkp_rdy, 1'b1);
    chk("x_rdreq", rdreq_x, 1'b1);
    chk("x_index", index_x, v.idx);
    @(negedge rclk);
    lkp_vld = 1'b0;
    tags[0] = v.t0; tags[1] = v.t1; tags[2] = v.t2; tags[3] = v.t3;
    #1;
    chk("y_rdy", lkp_rdy, v.hit);
    @(negedge rclk);
    tags = '0;
    #1;
    chk("res_vld", res_vld, 1'b1);
    chk("res_hit", res_hit, v.hit);
    chk("res_way", res_way, v.way);
    chk("res_mhit", res_mhit, v.mhit);
    chk("fill_req", fill_req, !v.hit);
    if (v.hit) begin
      @(negedge rclk);
      #1;
      chk("res_pulse", res_vld, 1'b0);
    end else begin
      chk("fill_index", fill_index, v.idx);
      chk("fill_ptag", fill_ptag, v.ptag);
      chk("fill_nowr", wrreq_x, 1'b0);
      for (int i = 0; i < v.ack_wait; i++) begin
        @(negedge rclk);
        #1;
        chk("fill_hold", fill_req, 1'b1);
        chk("fill_res_pulse", res_vld, 1'b0);
      end
      fill_ack = 1'b1;
      @(negedge rclk);
      fill_ack = 1'b0;
      #1;
      chk("tw_wrreq", wrreq_x, 1'b1);
      chk("tw_rdreq", rdreq_x, 1'b0);
      chk("tw_way", dec_wrway_x, v.victim);
      chk("tw_index", index_x, v.idx);
      chk("tw_wrtag", wrtag_y, {1'b1, v.ptag});
      chk("tw_fill_req", fill_req, 1'b0);
      @(negedge rclk);
      #1;
      chk("post_wrreq", wrreq_x, 1'b0);
      chk("post_way", dec_wrway_x, 4'b0000);
      chk("post_rdy", lkp_rdy, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_l = 1'b0; lkp_vld = 1'b0; lkp_index = '0; lkp_ptag = '0; tags = '0; fill_ack = 1'b0;

    vecs[0] = mk(7'd5, 32'h1234, {1'b1, 32'h1}, {1'b1, 32'h2}, {1'b1, 32'h1234},
                 {1'b0, 32'h1234}, 1'b1, 4'b0100, 1'b0, 4'b0000, 0);
    vecs[1] = mk(7'h7f, 32'hffff_ffff, {1'b1, 32'h7fff_ffff}, {1'b1, 32'hffff_ffff},
                 {1'b0, 32'hffff_ffff}, {1'b1, 32'hffff_fffe}, 1'b1, 4'b0010, 1'b0, 4'b0000, 0);
    vecs[2] = mk(7'd9, 32'habc, {1'b1, 32'habc}, {1'b1, 32'habd}, {1'b0, 32'h0},
                 {1'b1, 32'habc}, 1'b1, 4'b1001, 1'b1, 4'b0000, 0);
    vecs[3] = mk(7'd5, 32'h1234, {1'b1, 32'h1}, {1'b0, 32'h1234}, {1'b1, 32'h2},
                 {1'b1, 32'h3}, 1'b0, 4'b0000, 1'b0, 4'b0010, 2);
    vecs[4] = mk(7'd10, 32'h100, {1'b1, 32'h200}, {1'b1, 32'h201}, {1'b1, 32'h202},
                 {1'b1, 32'h203}, 1'b0, 4'b0000, 1'b0, 4'b0001, 0);
    vecs[5] = mk(7'd11, 32'h101, {1'b1, 32'h200}, {1'b1, 32'h201}, {1'b1, 32'h202},
                 {1'b1, 32'h203}, 1'b0, 4'b0000, 1'b0, 4'b0010, 0);
    vecs[6] = mk(7'd12, 32'h102, {1'b1, 32'h200}, {1'b1, 32'h201}, {1'b1, 32'h202},
                 {1'b0, 32'h102}, 1'b0, 4'b0000, 1'b0, 4'b1000, 1);
    vecs[7] = mk(7'd13, 32'h103, {1'b1, 32'h200}, {1'b1, 32'h201}, {1'b1, 32'h202},
                 {1'b1, 32'h203}, 1'b0, 4'b0000, 1'b0, 4'b0100, 0);
    vecs[8] = mk(7'd14, 32'h104, {1'b1, 32'h200}, {1'b1, 32'h201}, {1'b1, 32'h202},
                 {1'b1, 32'h203}, 1'b0, 4'b0000, 1'b0, 4'b1000, 0);
    vecs[9] = mk(7'd15, 32'h105, {1'b1, 32'h200}, {1'b1, 32'h201}, {1'b1, 32'h202},
                 {1'b1, 32'h203}, 1'b0, 4'b0000, 1'b0, 4'b0001, 0);

    // Reset state
    #1;
    chk("rst_rdy", lkp_rdy, 1'b1);
    chk("rst_res_vld", res_vld, 1'b0);
    chk("rst_res_way", res_way, 4'b0000);
    chk("rst_fill_req", fill_req, 1'b0);
    chk("rst_wrreq", wrreq_x, 1'b0);
    chk("rst_way", dec_wrway_x, 4'b0000);
    repeat (2) @(negedge rclk);
    reset_l = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Back-to-back hits: way (c-1) matches lookup c-1 during its Y cycle
    for (int c = 0; c < 7; c++) begin
      @(negedge rclk);
      lkp_vld   = (c < 4);
      lkp_index = 7'(20 + c);
      lkp_ptag  = 32'h5000 + 32'(c);
      tags      = '0;
      if (c >= 1 && c <= 4) tags[c-1] = {1'b1, 32'h5000 + 32'(c - 1)};
      #1;
      chk("b2b_rdreq", rdreq_x, (c < 4));
      chk("b2b_res_vld", res_vld, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) chk("b2b_res_way", res_way, 4'b0001 << (c - 2));
    end
    lkp_vld = 1'b0;

    // Y miss blocks the next X, then reset lands mid-fill (RR pointer is 1 here)
    @(negedge rclk);
    lkp_vld = 1'b1; lkp_index = 7'd30; lkp_ptag = 32'h777;
    #1;
    chk("blk_x_rdreq", rdreq_x, 1'b1);
    @(negedge rclk);
    lkp_index = 7'd31; lkp_ptag = 32'h888;
    tags = {4{{1'b1, 32'h1}}};
    #1;
    chk("blk_rdy", lkp_rdy, 1'b0);
    chk("blk_rdreq", rdreq_x, 1'b0);
    @(negedge rclk);
    lkp_vld = 1'b0; tags = '0;
    #1;
    chk("blk_fill_req", fill_req, 1'b1);
    chk("blk_fill_ptag", fill_ptag, 32'h777);
    @(negedge rclk);
    #1;
    chk("blk_fill_hold", fill_req, 1'b1);
    reset_l = 1'b0;
    #1;
    chk("mid_rst_fill_req", fill_req, 1'b0);
    chk("mid_rst_wrreq", wrreq_x, 1'b0);
    chk("mid_rst_rdy", lkp_rdy, 1'b1);
    @(negedge rclk);
    reset_l = 1'b1;
    fill_ack = 1'b1;
    #1;
    chk("rel_rdy", lkp_rdy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk);
      fill_ack = 1'b0;
      #1;
      chk("rel_wrreq", wrreq_x, 1'b0);
      chk("rel_fill_req", fill_req, 1'b0);
    end

    // RR pointer back at 0 after reset
    run_vec(mk(7'd40, 32'h9999, {1'b1, 32'h1}, {1'b1, 32'h2}, {1'b1, 32'h3},
               {1'b1, 32'h4}, 1'b0, 4'b0000, 1'b0, 4'b0001, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
